// File: rtl/instr_fetch_if.sv
// Loader handshake and fetch-port bundle between the CPU/loader side and instr_fetch.
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              reload;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              cpu_run;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output load_valid, load_data, load_last, reload, pc,
    input  load_ready, instruction, cpu_run, prog_len
  );

  modport slave (
    input  load_valid, load_data, load_last, reload, pc,
    output load_ready, instruction, cpu_run, prog_len
  );
endinterface

// File: rtl/instr_fetch.sv
// Program store filled by a byte loader, then read one instruction per cycle while the CPU runs.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_prog_len;
  logic [DATA_W-1:0] r_instr_p1;

  logic              w_ready;
  logic              w_run;
  logic              w_accept;
  logic              w_full;
  logic              w_reload;
  logic              w_hit;
  logic [ADDR_W:0]   w_pc_ext;

  assign w_accept = bus.load_valid & w_ready;
  assign w_full   = (r_wptr == LAST_ADDR);
  assign w_reload = w_run & bus.reload;
  assign w_pc_ext = {1'b0, bus.pc};
  assign w_hit    = (w_pc_ext < r_prog_len);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_next = (bus.load_last || w_full) ? S_RUN : S_LOAD;
      S_LOAD:  if (w_accept && (bus.load_last || w_full)) w_next = S_RUN;
      S_RUN:   if (bus.reload) w_next = S_EMPTY;
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_run   = 1'b0;
    case (r_state)
      S_EMPTY, S_LOAD: w_ready = 1'b1;
      S_RUN:           w_run   = 1'b1;
      default:         w_ready = 1'b0;
    endcase
  end

  // Memory is deliberately outside the reset domain; a stale program is hidden by PROG_LEN.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wptr] <= bus.load_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else if (w_reload) begin
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else if (w_accept) begin
      r_wptr     <= r_wptr + ADDR_W'(1);
      r_prog_len <= r_prog_len + (ADDR_W+1)'(1);
    end
  end

  // Fetch stage: PC -> instruction, one cycle; zero outside RUN and beyond the program.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_instr_p1 <= '0;
    else if (!w_run || w_reload) r_instr_p1 <= '0;
    else if (w_hit)           r_instr_p1 <= r_mem[bus.pc];
    else                      r_instr_p1 <= '0;
  end

  assign bus.load_ready  = w_ready;
  assign bus.cpu_run     = w_run;
  assign bus.prog_len    = r_prog_len;
  assign bus.instruction = r_instr_p1;

endmodule
